// File: rtl/mem_pkg.sv
// Shared types and defaults for the CPU/GPU main-memory arbiter.
package mem_pkg;

    localparam int unsigned ADDR_W_DEF = 10;
    localparam int unsigned DATA_W_DEF = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMD  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [1:0] ST_ACK  = 2'd3;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_GPU = 1'b1
    } owner_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone request wins outright, a tie goes to the
// client that was not granted last.
module rr_arb2
    import mem_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last_grant,
    output owner_t     winner,
    output logic       any
);

    always_comb begin
        any = |req;
        if (req == 2'b11) begin
            winner = (last_grant == OWN_GPU) ? OWN_CPU : OWN_GPU;
        end else if (req[1]) begin
            winner = OWN_GPU;
        end else begin
            winner = OWN_CPU;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates CPU and GPU word requests onto a single-outstanding memory backend.
// All outputs come from state or latched registers; no input reaches an output.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              gpu_req,
    input  logic              gpu_we,
    input  logic [ADDR_W-1:0] gpu_addr,
    input  logic [DATA_W-1:0] gpu_wdata,
    output logic              gpu_ack,
    output logic [DATA_W-1:0] gpu_rdata,
    output logic              mem_cmd_valid,
    input  logic              mem_cmd_ready,
    output logic              mem_cmd_we,
    output logic [ADDR_W-1:0] mem_cmd_addr,
    output logic [DATA_W-1:0] mem_cmd_wdata,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,
    output logic              err
);

    logic [1:0]        state_q;
    owner_t            owner_q;
    owner_t            last_grant_q;
    owner_t            winner;
    logic              any;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] gpu_rdata_q;
    logic              err_q;

    rr_arb2 u_arb (
        .req        ({gpu_req, cpu_req}),
        .last_grant (last_grant_q),
        .winner     (winner),
        .any        (any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_CPU;
            last_grant_q <= OWN_GPU;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cpu_rdata_q  <= '0;
            gpu_rdata_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            // A response is only legal while a read is waiting for it.
            if (mem_rsp_valid && (state_q != ST_RESP)) begin
                err_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (any) begin
                        owner_q <= winner;
                        if (winner == OWN_CPU) begin
                            we_q    <= cpu_we;
                            addr_q  <= cpu_addr;
                            wdata_q <= cpu_wdata;
                        end else begin
                            we_q    <= gpu_we;
                            addr_q  <= gpu_addr;
                            wdata_q <= gpu_wdata;
                        end
                        state_q <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (mem_cmd_ready) begin
                        state_q <= we_q ? ST_ACK : ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (mem_rsp_valid) begin
                        if (owner_q == OWN_CPU) begin
                            cpu_rdata_q <= mem_rsp_data;
                        end else begin
                            gpu_rdata_q <= mem_rsp_data;
                        end
                        state_q <= ST_ACK;
                    end
                end
                default: begin
                    last_grant_q <= owner_q;
                    state_q      <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_cmd_valid = (state_q == ST_CMD);
    assign mem_cmd_we    = we_q;
    assign mem_cmd_addr  = addr_q;
    assign mem_cmd_wdata = wdata_q;
    assign cpu_ack       = (state_q == ST_ACK) && (owner_q == OWN_CPU);
    assign gpu_ack       = (state_q == ST_ACK) && (owner_q == OWN_GPU);
    assign cpu_rdata     = cpu_rdata_q;
    assign gpu_rdata     = gpu_rdata_q;
    assign err           = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios plus randomized rounds
// checked against a transaction-level model of round-robin arbitration.
module tb_mem_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic          gpu_req = 1'b0, gpu_we = 1'b0;
    logic [AW-1:0] gpu_addr = '0;
    logic [DW-1:0] gpu_wdata = '0;
    logic          gpu_ack;
    logic [DW-1:0] gpu_rdata;
    logic          mem_cmd_valid, mem_cmd_we;
    logic          mem_cmd_ready = 1'b0;
    logic [AW-1:0] mem_cmd_addr;
    logic [DW-1:0] mem_cmd_wdata;
    logic          mem_rsp_valid = 1'b0;
    logic [DW-1:0] mem_rsp_data = '0;
    logic          err;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .gpu_req(gpu_req), .gpu_we(gpu_we), .gpu_addr(gpu_addr), .gpu_wdata(gpu_wdata),
        .gpu_ack(gpu_ack), .gpu_rdata(gpu_rdata),
        .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready), .mem_cmd_we(mem_cmd_we),
        .mem_cmd_addr(mem_cmd_addr), .mem_cmd_wdata(mem_cmd_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .err(err)
    );

    typedef struct {
        bit            own;   // 0 = CPU, 1 = GPU
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } txn_t;

    txn_t          exp_cmd[$];
    txn_t          exp_ack[$];
    int            grant_log[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    bit            last_model = 1'b1;
    bit            err_model = 1'b0;
    logic [DW-1:0] refmem[0:1023];
    logic [DW-1:0] bmem[0:1023];
    logic [DW-1:0] cpu_rd_model = '0;
    logic [DW-1:0] gpu_rd_model = '0;
    int            ready_mode = 1;  // 0 random, 1 always, 2 low for five cycles per command
    int            rsp_delay = 2;   // 0 = random 1..4
    bit            stray = 1'b0;
    int            last_acc_cyc = 0, last_ack_cyc = 0, last_cmd_len = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endtask

    task automatic push_exp(input txn_t t);
        if (t.we) refmem[t.addr] = t.wdata;
        else t.rdata = refmem[t.addr];
        exp_cmd.push_back(t);
        exp_ack.push_back(t);
    endtask

    // Monitor: compares every accepted command and every acknowledge against the queues.
    initial begin
        bit            pv = 1'b0;
        logic          pwe = 1'b0;
        logic [AW-1:0] pa = '0;
        logic [DW-1:0] pd = '0;
        int            len = 0;
        txn_t          t;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 1'b0;
                len = 0;
            end else begin
                if (mem_cmd_valid) begin
                    len++;
                    if (pv) begin
                        check("cmd_hold_we", 64'(mem_cmd_we), 64'(pwe));
                        check("cmd_hold_addr", 64'(mem_cmd_addr), 64'(pa));
                        check("cmd_hold_wdata", 64'(mem_cmd_wdata), 64'(pd));
                    end
                    if (mem_cmd_ready) begin
                        checks++;
                        if (exp_cmd.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_cmd: addr %0h, expected none", mem_cmd_addr);
                        end else begin
                            t = exp_cmd.pop_front();
                            check("cmd_we", 64'(mem_cmd_we), 64'(t.we));
                            check("cmd_addr", 64'(mem_cmd_addr), 64'(t.addr));
                            if (t.we) check("cmd_wdata", 64'(mem_cmd_wdata), 64'(t.wdata));
                        end
                        last_acc_cyc = cyc;
                        last_cmd_len = len;
                        len = 0;
                        pv = 1'b0;
                    end else begin
                        pv = 1'b1;
                        pwe = mem_cmd_we;
                        pa = mem_cmd_addr;
                        pd = mem_cmd_wdata;
                    end
                end else begin
                    if (pv) check("cmd_hold_valid", 64'(mem_cmd_valid), 64'd1);
                    pv = 1'b0;
                    len = 0;
                end
                if (cpu_ack || gpu_ack) begin
                    check("ack_exclusive", 64'(cpu_ack && gpu_ack), 64'd0);
                    checks++;
                    if (exp_ack.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_ack: cpu %0d gpu %0d, expected none",
                                 cpu_ack, gpu_ack);
                    end else begin
                        t = exp_ack.pop_front();
                        check("ack_owner", 64'(gpu_ack), 64'(t.own));
                        if (!t.we) begin
                            if (t.own) gpu_rd_model = t.rdata;
                            else cpu_rd_model = t.rdata;
                        end
                        check("cpu_rdata", 64'(cpu_rdata), 64'(cpu_rd_model));
                        check("gpu_rdata", 64'(gpu_rdata), 64'(gpu_rd_model));
                        check("err_at_ack", 64'(err), 64'(err_model));
                    end
                    last_ack_cyc = cyc;
                    grant_log.push_back(int'(gpu_ack));
                end
            end
        end
    end

    // Backend: RAM with configurable command stall and read latency.
    initial begin
        logic [DW-1:0] rv = '0;
        int            cnt = 0;
        int            hold = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                cnt = 0;
                hold = 0;
            end else if (mem_cmd_valid && mem_cmd_ready) begin
                hold = 0;
                if (mem_cmd_we) begin
                    bmem[mem_cmd_addr] = mem_cmd_wdata;
                end else begin
                    rv = bmem[mem_cmd_addr];
                    cnt = (rsp_delay > 0) ? rsp_delay : int'($urandom_range(1, 4));
                end
            end else if (mem_cmd_valid) begin
                hold++;
            end
            @(posedge clk);
            #1;
            mem_rsp_valid = 1'b0;
            mem_rsp_data = DW'($urandom);
            if (stray) begin
                mem_rsp_valid = 1'b1;
                stray = 1'b0;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    mem_rsp_valid = 1'b1;
                    mem_rsp_data = rv;
                end
            end
            case (ready_mode)
                0:       mem_cmd_ready = ($urandom_range(0, 2) != 0);
                2:       mem_cmd_ready = (hold >= 5);
                default: mem_cmd_ready = 1'b1;
            endcase
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_cmd.delete();
        exp_ack.delete();
        last_model = 1'b1;
        cpu_rd_model = '0;
        gpu_rd_model = '0;
        err_model = 1'b0;
    endtask

    task automatic check_reset();
        check("rst_cpu_ack", 64'(cpu_ack), 64'd0);
        check("rst_gpu_ack", 64'(gpu_ack), 64'd0);
        check("rst_cmd_valid", 64'(mem_cmd_valid), 64'd0);
        check("rst_cmd_we", 64'(mem_cmd_we), 64'd0);
        check("rst_cmd_addr", 64'(mem_cmd_addr), 64'd0);
        check("rst_cmd_wdata", 64'(mem_cmd_wdata), 64'd0);
        check("rst_cpu_rdata", 64'(cpu_rdata), 64'd0);
        check("rst_gpu_rdata", 64'(gpu_rdata), 64'd0);
        check("rst_err", 64'(err), 64'd0);
    endtask

    // One round: the chosen clients request together and each holds until its ack.
    task automatic run_round(input bit dc, input bit dg, input txn_t c, input txn_t g,
                             output int start);
        bit got_c, got_g, ac, ag;
        c.own = 1'b0;
        g.own = 1'b1;
        if (dc && dg) begin
            if (last_model) begin
                push_exp(c);
                push_exp(g);
                last_model = 1'b1;
            end else begin
                push_exp(g);
                push_exp(c);
                last_model = 1'b0;
            end
        end else if (dc) begin
            push_exp(c);
            last_model = 1'b0;
        end else begin
            push_exp(g);
            last_model = 1'b1;
        end
        @(posedge clk);
        #1;
        start = cyc;
        if (dc) begin
            cpu_req = 1'b1; cpu_we = c.we; cpu_addr = c.addr; cpu_wdata = c.wdata;
        end
        if (dg) begin
            gpu_req = 1'b1; gpu_we = g.we; gpu_addr = g.addr; gpu_wdata = g.wdata;
        end
        got_c = !dc;
        got_g = !dg;
        for (int i = 0; i < 400 && !(got_c && got_g); i++) begin
            @(negedge clk);
            ac = cpu_ack;
            ag = gpu_ack;
            @(posedge clk);
            #1;
            if (ac) begin got_c = 1'b1; cpu_req = 1'b0; end
            if (ag) begin got_g = 1'b1; gpu_req = 1'b0; end
            // Idle client fields wander; they must not leak into anything.
            if (got_c) begin
                cpu_we = 1'($urandom); cpu_addr = AW'($urandom); cpu_wdata = DW'($urandom);
            end
            if (got_g) begin
                gpu_we = 1'($urandom); gpu_addr = AW'($urandom); gpu_wdata = DW'($urandom);
            end
        end
        checks++;
        if (!(got_c && got_g)) begin
            errors++;
            $display("FAIL round_timeout: cpu_done %0d gpu_done %0d, expected both 1",
                     got_c, got_g);
        end
    endtask

    initial begin
        txn_t c, g;
        int   s;
        bit   seen;
        c = '{own: 1'b0, we: 1'b0, addr: '0, wdata: '0, rdata: '0};
        g = c;
        for (int i = 0; i < 1024; i++) begin
            refmem[i] = DW'(i) * 32'h9E37_79B1;
            bmem[i] = refmem[i];
        end
        refmem[10'h3FF] = 32'h1234_5678;
        bmem[10'h3FF] = 32'h1234_5678;

        do_reset();
        @(negedge clk);
        check_reset();

        // CPU write: command in cycle 1, ack in cycle 2.
        ready_mode = 1;
        rsp_delay = 2;
        c.we = 1'b1; c.addr = 10'h005; c.wdata = 32'hDEAD_BEEF;
        grant_log.delete();
        run_round(1'b1, 1'b0, c, g, s);
        check("wr_cmd_cycle", 64'(last_acc_cyc - s), 64'd1);
        check("wr_ack_cycle", 64'(last_ack_cyc - s), 64'd2);
        check("wr_ack_count", 64'(grant_log.size()), 64'd1);

        // GPU read with response two cycles after acceptance.
        g.we = 1'b0; g.addr = 10'h3FF;
        run_round(1'b0, 1'b1, c, g, s);
        check("rd_ack_latency", 64'(last_ack_cyc - last_acc_cyc), 64'd3);
        check("rd_gpu_data", 64'(gpu_rdata), 64'h1234_5678);

        // Ties from reset alternate, CPU first.
        do_reset();
        grant_log.delete();
        for (int r = 0; r < 3; r++) begin
            c.we = 1'b1; c.addr = AW'(20 + r); c.wdata = DW'($urandom);
            g.we = 1'b0; g.addr = AW'(20 + r);
            run_round(1'b1, 1'b1, c, g, s);
        end
        check("tie_count", 64'(grant_log.size()), 64'd6);
        for (int r = 0; r < 6 && r < grant_log.size(); r++) begin
            check("tie_order", 64'(grant_log[r]), 64'(r % 2));
        end

        // Backend stalls five cycles: six stable valid cycles, one command, one ack.
        ready_mode = 2;
        grant_log.delete();
        c.we = 1'b1; c.addr = 10'h0AA; c.wdata = 32'hCAFE_F00D;
        run_round(1'b1, 1'b0, c, g, s);
        check("stall_valid_cycles", 64'(last_cmd_len), 64'd6);
        check("stall_ack_count", 64'(grant_log.size()), 64'd1);
        ready_mode = 1;

        // Stray response while idle sets a sticky error.
        @(negedge clk);
        stray = 1'b1;
        repeat (3) @(negedge clk);
        check("stray_err", 64'(err), 64'd1);
        err_model = 1'b1;
        g.we = 1'b1; g.addr = 10'h0AB; g.wdata = 32'h0BAD_F00D;
        run_round(1'b0, 1'b1, c, g, s);
        @(negedge clk);
        check("stray_err_sticky", 64'(err), 64'd1);
        do_reset();
        @(negedge clk);
        check("err_cleared", 64'(err), 64'd0);

        // Reset while a CPU read waits for its response.
        rsp_delay = 5;
        c.we = 1'b0; c.addr = 10'h005; c.own = 1'b0;
        push_exp(c);
        @(posedge clk);
        #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h005; cpu_wdata = '0;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = mem_cmd_valid && mem_cmd_ready;
        end
        check("rstmid_accepted", 64'(seen), 64'd1);
        cpu_req = 1'b0;
        do_reset();
        @(negedge clk);
        check_reset();
        for (int i = 0; i < 6; i++) begin
            check("rstmid_no_ack", 64'(cpu_ack || gpu_ack), 64'd0);
            @(negedge clk);
        end
        grant_log.delete();
        rsp_delay = 2;
        c.we = 1'b0; c.addr = 10'h005;
        g.we = 1'b0; g.addr = 10'h006;
        run_round(1'b1, 1'b1, c, g, s);
        check("rstmid_tie_first", 64'(grant_log.size() > 0 ? grant_log[0] : 9), 64'd0);

        // Randomized rounds.
        ready_mode = 0;
        rsp_delay = 0;
        for (int r = 0; r < 80; r++) begin
            int pick;
            pick = int'($urandom_range(1, 3));
            c.we = 1'($urandom); c.addr = AW'($urandom_range(0, 15)); c.wdata = DW'($urandom);
            g.we = 1'($urandom); g.addr = AW'($urandom_range(0, 15)); g.wdata = DW'($urandom);
            run_round(pick[0], pick[1], c, g, s);
        end

        repeat (5) @(negedge clk);
        check("cmd_queue_empty", 64'(exp_cmd.size()), 64'd0);
        check("ack_queue_empty", 64'(exp_ack.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
